// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment scan path.
// Scan-state encoding plus width/mask utility functions.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    ON
  } scan_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // All-ones in the low n bits; callers slice to their width.
  function automatic logic [31:0] ANODES_OFF(input int n);
    if (n >= 32) return '1;
    return (32'h1 << n) - 32'h1;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Programmable scan-tick prescaler.
// Ticks when the count reaches tick_div; idles cleared when not running.
module scan_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] tick_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] r_cnt;

  // >= so a lowered reload takes effect immediately
  assign tick = run && (r_cnt >= tick_div);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!run || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/digit_scan_driver.sv
// Time-multiplexed anode driver for common-anode 7-seg displays.
// Descending scan with optional blanking guard and per-digit mask.
module digit_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int GUARD_TICKS = 1,
  parameter int ON_TICKS    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          tick_div,
  input  logic [NUM_DIGITS-1:0]         digit_mask,
  output logic [NUM_DIGITS-1:0]         anodes,
  output logic [clog2(NUM_DIGITS)-1:0]  digit_sel,
  output logic                          digit_strobe
);

  localparam int SW   = clog2(NUM_DIGITS);
  localparam int MAXT =
    (GUARD_TICKS > ON_TICKS) ? GUARD_TICKS : ON_TICKS;
  localparam int PW   = clog2(MAXT + 1);

  localparam logic [NUM_DIGITS-1:0] OFF =
    NUM_DIGITS'(ANODES_OFF(NUM_DIGITS));
  localparam logic [SW-1:0] TOP = SW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] G_LAST =
    PW'((GUARD_TICKS > 0) ? GUARD_TICKS - 1 : 0);
  localparam logic [PW-1:0] O_LAST = PW'(ON_TICKS - 1);
  localparam scan_state_t FIRST =
    (GUARD_TICKS == 0) ? ON : BLANK;

  scan_state_t r_state, w_state_n;
  logic [PW-1:0] r_phase, w_phase_n;
  logic [SW-1:0] r_sel, w_sel_n;
  logic [NUM_DIGITS-1:0] r_an, w_an_n;
  logic r_strobe, w_strobe_n;
  logic w_tick, w_run;

  assign w_run = enable && (r_state != IDLE);

  scan_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_presc (
    .clk      (clk),
    .reset    (reset),
    .run      (w_run),
    .tick_div (tick_div),
    .tick     (w_tick)
  );

  always_comb begin
    w_state_n  = r_state;
    w_phase_n  = r_phase;
    w_sel_n    = r_sel;
    w_strobe_n = 1'b0;
    if (!enable) begin
      w_state_n = IDLE;
      w_phase_n = '0;
      w_sel_n   = TOP;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_n  = FIRST;
          w_phase_n  = '0;
          w_sel_n    = TOP;
          w_strobe_n = 1'b1;
        end
        BLANK: begin
          if (w_tick) begin
            if (r_phase == G_LAST) begin
              w_state_n = ON;
              w_phase_n = '0;
            end else begin
              w_phase_n = r_phase + PW'(1);
            end
          end
        end
        ON: begin
          if (w_tick) begin
            if (r_phase == O_LAST) begin
              w_state_n  = FIRST;
              w_phase_n  = '0;
              w_sel_n    = (r_sel == '0) ? TOP
                                         : r_sel - SW'(1);
              w_strobe_n = 1'b1;
            end else begin
              w_phase_n = r_phase + PW'(1);
            end
          end
        end
        default: begin
          w_state_n = IDLE;
          w_phase_n = '0;
          w_sel_n   = TOP;
        end
      endcase
    end
  end

  // Anodes follow the next state so lighting lines up with it
  always_comb begin
    w_an_n = OFF;
    if (w_state_n == ON && digit_mask[w_sel_n]) begin
      w_an_n[w_sel_n] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_sel    <= TOP;
      r_an     <= OFF;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_phase  <= w_phase_n;
      r_sel    <= w_sel_n;
      r_an     <= w_an_n;
      r_strobe <= w_strobe_n;
    end
  end

  assign anodes       = r_an;
  assign digit_sel    = r_sel;
  assign digit_strobe = r_strobe;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Scoreboard bench for digit_scan_driver (4-digit guarded and
// 6-digit unguarded instances).
module tb_digit_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic en4, en6;
  logic [15:0] td4, td6;
  logic [3:0] m4;
  logic [5:0] m6;
  logic [3:0] an4;
  logic [1:0] sel4;
  logic st4;
  logic [5:0] an6;
  logic [2:0] sel6;
  logic st6;

  typedef struct packed {
    logic [5:0] an;
    logic [2:0] sel;
    logic       st;
  } exp_t;

  exp_t q4[$];
  exp_t q6[$];
  int total = 0;
  int bad = 0;

  digit_scan_driver #(
    .NUM_DIGITS(4), .DIV_WIDTH(16),
    .GUARD_TICKS(1), .ON_TICKS(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(en4),
    .tick_div(td4), .digit_mask(m4),
    .anodes(an4), .digit_sel(sel4),
    .digit_strobe(st4)
  );

  digit_scan_driver #(
    .NUM_DIGITS(6), .DIV_WIDTH(16),
    .GUARD_TICKS(0), .ON_TICKS(1)
  ) dut6 (
    .clk(clk), .reset(reset), .enable(en6),
    .tick_div(td6), .digit_mask(m6),
    .anodes(an6), .digit_sel(sel6),
    .digit_strobe(st6)
  );

  always @(negedge clk) begin : mon
    exp_t e;
    exp_t g;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      g.an = {2'b00, an4};
      g.sel = {1'b0, sel4};
      g.st = st4;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL scan4 t=%0t an/sel/strobe got %b/%0d/%b want %b/%0d/%b",
                 $time, an4, sel4, st4, e.an[3:0], e.sel, e.st);
      end
    end
    if (q6.size() > 0) begin
      e = q6.pop_front();
      g.an = an6;
      g.sel = sel6;
      g.st = st6;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL scan6 t=%0t an/sel/strobe got %b/%0d/%b want %b/%0d/%b",
                 $time, an6, sel6, st6, e.an, e.sel, e.st);
      end
    end
  end

  task automatic p4(input logic [3:0] an, input int sel,
                    input logic st, input int n = 1);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.an = {2'b00, an};
      e.sel = 3'(sel);
      e.st = (i == 0) ? st : 1'b0;
      q4.push_back(e);
    end
  endtask

  task automatic p6(input logic [5:0] an, input int sel,
                    input logic st, input int n = 1);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.an = an;
      e.sel = 3'(sel);
      e.st = (i == 0) ? st : 1'b0;
      q6.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((q4.size() > 0 || q6.size() > 0) && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (q4.size() > 0 || q6.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain %s left=%0d want 0", name,
               q4.size() + q6.size());
      q4.delete();
      q6.delete();
    end
    step(1);
  endtask

  initial begin
    reset = 1'b1;
    en4 = 1'b0;
    en6 = 1'b0;
    td4 = 16'd0;
    td6 = 16'd0;
    m4 = 4'hF;
    m6 = 6'h3F;
    step(1);
    p4(4'hF, 3, 0, 3);
    p6(6'h3F, 5, 0, 3);
    step(1);
    reset = 1'b0;
    drain("reset");

    // basic scan, disable while digit 1 lit, re-enable, mid reset
    p4(4'hF, 3, 0); p4(4'hF, 3, 1); p4(4'h7, 3, 0);
    p4(4'hF, 2, 1); p4(4'hB, 2, 0); p4(4'hF, 1, 1);
    p4(4'hD, 1, 0); p4(4'hF, 0, 1); p4(4'hE, 0, 0);
    p4(4'hF, 3, 1); p4(4'h7, 3, 0); p4(4'hF, 2, 1);
    p4(4'hB, 2, 0); p4(4'hF, 1, 1); p4(4'hD, 1, 0);
    p4(4'hF, 3, 0, 2);
    p4(4'hF, 3, 1); p4(4'h7, 3, 0); p4(4'hF, 2, 1);
    p4(4'hF, 3, 0);
    p4(4'hF, 3, 1); p4(4'h7, 3, 0);
    p4(4'hF, 3, 0, 2);
    en4 = 1'b1;
    step(14); en4 = 1'b0;
    step(2);  en4 = 1'b1;
    step(3);  reset = 1'b1;
    step(1);  reset = 1'b0;
    step(2);  en4 = 1'b0;
    drain("basic");

    // slow scan, mask change while digit 3 lit
    td4 = 16'd3;
    p4(4'hF, 3, 0); p4(4'hF, 3, 1, 4);
    p4(4'h7, 3, 0, 2); p4(4'hF, 3, 0, 2);
    p4(4'hF, 2, 1, 4); p4(4'hB, 2, 0, 4);
    p4(4'hF, 1, 1, 4); p4(4'hD, 1, 0, 4);
    p4(4'hF, 0, 1, 4); p4(4'hE, 0, 0, 4);
    p4(4'hF, 3, 1, 4); p4(4'hF, 3, 0, 1);
    p4(4'hF, 3, 0, 2);
    en4 = 1'b1;
    step(6);  m4 = 4'b0111;
    step(31); en4 = 1'b0;
    drain("div3");

    // leading digits masked off
    td4 = 16'd0;
    m4 = 4'b0011;
    p4(4'hF, 3, 0); p4(4'hF, 3, 1, 2); p4(4'hF, 2, 1, 2);
    p4(4'hF, 1, 1); p4(4'hD, 1, 0); p4(4'hF, 0, 1);
    p4(4'hE, 0, 0); p4(4'hF, 3, 1, 2); p4(4'hF, 3, 0, 2);
    en4 = 1'b1;
    step(10); en4 = 1'b0;
    drain("mask");
    m4 = 4'hF;

    // no guard, 6 digits
    p6(6'h3F, 5, 0); p6(6'h1F, 5, 1); p6(6'h2F, 4, 1);
    p6(6'h37, 3, 1); p6(6'h3B, 2, 1); p6(6'h3D, 1, 1);
    p6(6'h3E, 0, 1); p6(6'h1F, 5, 1); p6(6'h3F, 5, 0, 2);
    en6 = 1'b1;
    step(7); en6 = 1'b0;
    drain("noguard");

    // reload lowered mid-count
    td4 = 16'd100;
    p4(4'hF, 3, 0); p4(4'hF, 3, 1, 51);
    p4(4'h7, 3, 0, 3); p4(4'hF, 2, 1, 3);
    p4(4'hB, 2, 0, 3); p4(4'hF, 1, 1);
    p4(4'hF, 3, 0, 2);
    en4 = 1'b1;
    step(51); td4 = 16'd2;
    step(10); en4 = 1'b0;
    drain("reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_scan_driver.md
# digit_scan_driver

Parametrised time-multiplexing controller for common-anode seven-segment displays. It generalises the fixed 4-digit anode decoder to NUM_DIGITS digits and adds its own programmable prescaler and a configurable blanking (ghost-suppression) interval between digits. Per-digit masking supports leading-zero suppression. The block drives the active-low anode lines and tells the segment-data path which digit is current. It sits between the display top level and the per-digit segment encoder.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (2..16)
- DIV_WIDTH, 16, width of prescaler reload value
- GUARD_TICKS, 1, scan ticks of all-off blanking before each digit (0 = no blanking)
- ON_TICKS, 1, scan ticks each digit stays lit (≥1)
- Reset is synchronous and active-high; single clock domain.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- enable  in  1  scan enable; low forces display dark and idle
- tick_div  in  DIV_WIDTH  prescaler reload; scan tick every tick_div+1 cycles
- digit_mask  in  NUM_DIGITS  per-digit lit enable (1 = may light)
- anodes  out  NUM_DIGITS  active-low anode drive, registered
- digit_sel  out  clog2(NUM_DIGITS)  index of current digit, registered
- digit_strobe  out  1  one-cycle pulse when digit_sel takes a new value

## Operation
- Scan order: highest index first, descending, wrap NUM_DIGITS-1 after 0 (an3, an2, an1, an0 for N=4).
- Prescaler: cnt increments each cycle while not IDLE. A tick is generated in the cycle cnt >= tick_div, and cnt clears on that cycle. tick_div=0 ticks every cycle. The >= compare means that lowering tick_div mid-count gives a tick on the next cycle.
- FSM states: IDLE, BLANK, ON. A phase counter counts ticks within BLANK and ON.
- IDLE: anodes all 1, digit_sel = NUM_DIGITS-1, cnt = 0. When enable = 1, go to BLANK (or straight to ON if GUARD_TICKS=0) with digit_sel = NUM_DIGITS-1 and digit_strobe = 1.
- BLANK: anodes all 1. After GUARD_TICKS ticks, go to ON.
- ON: anodes = all 1 except bit digit_sel = 0, but only if digit_mask[digit_sel] = 1; otherwise anodes stay all 1. digit_mask is re-sampled every cycle with 1-cycle latency. After ON_TICKS ticks, advance digit_sel (with wrap), pulse digit_strobe, and go to BLANK (or stay in ON for the new digit if GUARD_TICKS=0).
- enable = 0 in any state: next cycle is IDLE with IDLE outputs. An in-progress digit is abandoned, and no strobe is issued.
- At most one anode bit is ever 0. Anodes never change from one lit digit directly to another when GUARD_TICKS ≥ 1.

## Timing
- Reset values: anodes = all 1, digit_sel = NUM_DIGITS-1, digit_strobe = 0, state = IDLE, cnt = 0, phase = 0.
- All outputs are registered and change only on clk edges.
- Enable seen high at edge k: digit_strobe = 1 and digit_sel = N-1 at k+1. First anode goes low at k+1+(tick_div+1)*GUARD_TICKS.
- Digit period = (tick_div+1)*(GUARD_TICKS+ON_TICKS) cycles. Frame period = NUM_DIGITS times the digit period.
- digit_strobe is high for exactly one cycle, coincident with the new digit_sel value. It leads lighting by (tick_div+1)*GUARD_TICKS cycles, which gives the segment path time to load.
- Reset asserted mid-scan wins over enable. Outputs hold reset values in the cycle after the reset edge.

## Structure
- Shared package display_pkg holds:
  - the scan_state_t enum (IDLE, BLANK, ON);
  - an ANODES_OFF helper function (all-ones of width N);
  - the digit-index width function, clog2.
- Sub-module scan_prescaler (clk, reset, run, tick_div → tick) holds the counter. The FSM, phase counter and output registers stay in the top module.

## Test plan
- N=4, tick_div=0, GUARD=1, ON=1, mask=1111, enable set after reset → anodes sequence per cycle: 1111, 0111, 1111, 1011, 1111, 1101, 1111, 1110, 1111, 0111 (wrap). digit_strobe pulses with digit_sel = 3, 2, 1, 0, 3.
- Same configuration, tick_div=3 → each anode low for exactly 4 cycles, and 4 blank cycles between digits. Frame = 32 cycles.
- mask=0011 → an3 and an2 never low. Timing of an1 and an0 is unchanged, and strobes still occur for all 4 digits.
- GUARD=0, N=6 → lit digit moves directly between digits: 011111, 101111, … 111110, then back to 011111. Every cycle has exactly one anode low.
- Mid-scan checks:
  - deassert enable while digit 1 is lit → anodes = 111111 next cycle, digit_sel = N-1, no strobe;
  - re-enable → restart from the top digit;
  - assert reset mid-scan → same reset-value check.
- tick_div changed from 100 to 2 while cnt = 50 → tick on the next cycle, then a tick every 3 cycles.
